// File: rtl/on_off_flow_tracker.sv
// On/off flow-control tracker: per (port, downstream VC) outstanding-flit counter
// with hysteresis gating that feeds the switch allocator's on_off input.

module on_off_vc_cell #(
  parameter int BUFFER_SIZE   = 8,
  parameter int OFF_THRESHOLD = 6,
  parameter int ON_THRESHOLD  = 4,
  parameter int CNT_W         = $clog2(BUFFER_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic             on,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);
  logic [CNT_W-1:0] cnt_n;
  logic             on_n;

  always_comb begin
    cnt_n = cnt;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (inc && !dec) begin
      if (cnt == CNT_W'(BUFFER_SIZE)) ovf = 1'b1;
      else                            cnt_n = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) unf = 1'b1;
      else           cnt_n = cnt - 1'b1;
    end
  end

  // Hysteresis looks at the post-update count so gating tracks the same edge.
  always_comb begin
    on_n = on;
    if (on && cnt_n >= CNT_W'(OFF_THRESHOLD))      on_n = 1'b0;
    else if (!on && cnt_n <= CNT_W'(ON_THRESHOLD)) on_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      on  <= 1'b1;
    end else begin
      cnt <= cnt_n;
      on  <= on_n;
    end
  end
endmodule

module on_off_flow_tracker #(
  parameter int PORT_NUM      = 5,
  parameter int VC_NUM        = 2,
  parameter int BUFFER_SIZE   = 8,
  parameter int OFF_THRESHOLD = 6,
  parameter int ON_THRESHOLD  = 4,
  localparam int VC_SIZE      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CNT_W        = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORT_NUM-1:0]               flit_sent_i,
  input  logic [PORT_NUM*VC_SIZE-1:0]       flit_sent_vc_i,
  input  logic [PORT_NUM*VC_NUM-1:0]        flit_freed_i,
  output logic [PORT_NUM*VC_NUM-1:0]        on_off_o,
  output logic [PORT_NUM*VC_NUM*CNT_W-1:0]  occupancy_o,
  output logic                              overflow_err_o,
  output logic                              underflow_err_o
);
  if (!(ON_THRESHOLD < OFF_THRESHOLD && OFF_THRESHOLD <= BUFFER_SIZE)) begin : g_bad_cfg
    $error("on_off_flow_tracker: need ON_THRESHOLD < OFF_THRESHOLD <= BUFFER_SIZE");
  end

  logic [PORT_NUM*VC_NUM-1:0] ovf_vec, unf_vec;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      localparam int IDX = p*VC_NUM + v;
      // VC ids at or beyond VC_NUM match no cell and are dropped.
      logic inc;
      assign inc = flit_sent_i[p] &&
                   (flit_sent_vc_i[p*VC_SIZE +: VC_SIZE] == VC_SIZE'(v));

      on_off_vc_cell #(
        .BUFFER_SIZE  (BUFFER_SIZE),
        .OFF_THRESHOLD(OFF_THRESHOLD),
        .ON_THRESHOLD (ON_THRESHOLD),
        .CNT_W        (CNT_W)
      ) u_cell (
        .clk(clk),
        .rst(rst),
        .inc(inc),
        .dec(flit_freed_i[IDX]),
        .on (on_off_o[IDX]),
        .cnt(occupancy_o[IDX*CNT_W +: CNT_W]),
        .ovf(ovf_vec[IDX]),
        .unf(unf_vec[IDX])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err_o  <= 1'b0;
      underflow_err_o <= 1'b0;
    end else begin
      overflow_err_o  <= overflow_err_o  | (|ovf_vec);
      underflow_err_o <= underflow_err_o | (|unf_vec);
    end
  end
endmodule

// File: tb/tb_on_off_flow_tracker.sv
// Directed + randomized check of on_off_flow_tracker against an occupancy/hysteresis model.

module tb_on_off_flow_tracker;
  localparam int PN = 5, VN = 2, BS = 8, OFFT = 6, ONT = 4, CW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PN-1:0]     flit_sent_i    = '0;
  logic [PN-1:0]     flit_sent_vc_i = '0;
  logic [PN*VN-1:0]  flit_freed_i   = '0;
  logic [PN*VN-1:0]  on_off_o;
  logic [PN*VN*CW-1:0] occupancy_o;
  logic              overflow_err_o, underflow_err_o;

  int n_chk = 0, n_fail = 0;

  int m_cnt [PN][VN];
  bit m_on  [PN][VN];
  bit m_ovf, m_unf;

  on_off_flow_tracker #(
    .PORT_NUM(PN), .VC_NUM(VN), .BUFFER_SIZE(BS),
    .OFF_THRESHOLD(OFFT), .ON_THRESHOLD(ONT)
  ) dut (
    .clk(clk), .rst(rst),
    .flit_sent_i(flit_sent_i), .flit_sent_vc_i(flit_sent_vc_i),
    .flit_freed_i(flit_freed_i), .on_off_o(on_off_o),
    .occupancy_o(occupancy_o), .overflow_err_o(overflow_err_o),
    .underflow_err_o(underflow_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < PN; p++)
      for (int v = 0; v < VN; v++) begin
        m_cnt[p][v] = 0;
        m_on[p][v]  = 1'b1;
      end
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Outstanding flits = sent - freed, clamped to [0, BS]; gate with hysteresis band.
  task automatic model_update(input logic [PN-1:0] s, input logic [PN-1:0] vcs,
                              input logic [PN*VN-1:0] fr);
    for (int p = 0; p < PN; p++)
      for (int v = 0; v < VN; v++) begin
        int delta;
        delta = ((s[p] && int'(vcs[p]) == v) ? 1 : 0) - (fr[p*VN+v] ? 1 : 0);
        if (m_cnt[p][v] + delta > BS) m_ovf = 1'b1;
        else if (m_cnt[p][v] + delta < 0) m_unf = 1'b1;
        else m_cnt[p][v] += delta;
        if (m_cnt[p][v] >= OFFT) m_on[p][v] = 1'b0;
        else if (m_cnt[p][v] <= ONT) m_on[p][v] = 1'b1;
      end
  endtask

  task automatic check_all(input string tag);
    logic [PN*VN-1:0]    e_on;
    logic [PN*VN*CW-1:0] e_occ;
    for (int p = 0; p < PN; p++)
      for (int v = 0; v < VN; v++) begin
        e_on[p*VN+v] = m_on[p][v];
        e_occ[(p*VN+v)*CW +: CW] = CW'(m_cnt[p][v]);
      end
    chk({tag, ".on_off"}, 64'(on_off_o), 64'(e_on));
    chk({tag, ".occ"},    64'(occupancy_o), 64'(e_occ));
    chk({tag, ".errs"},   64'({overflow_err_o, underflow_err_o}), 64'({m_ovf, m_unf}));
  endtask

  task automatic step(input string tag, input logic [PN-1:0] s,
                      input logic [PN-1:0] vcs, input logic [PN*VN-1:0] fr);
    @(negedge clk);
    flit_sent_i = s; flit_sent_vc_i = vcs; flit_freed_i = fr;
    @(posedge clk);
    model_update(s, vcs, fr);
    #1;
    flit_sent_i = '0; flit_sent_vc_i = '0; flit_freed_i = '0;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    chk("por.on_off_const", 64'(on_off_o), 64'h3FF);
    @(negedge clk);
    rst = 1'b0;

    // Port 0 VC 1 fills until it turns off.
    for (int i = 1; i <= 6; i++) step("fill", 5'b00001, 5'b00001, '0);
    chk("fill.occ01", 64'(occupancy_o[1*CW +: CW]), 64'd6);
    chk("fill.off01", 64'(on_off_o), 64'h3FD);

    step("free5", '0, '0, 10'b10);
    chk("free5.still_off", 64'(on_off_o[1]), 64'd0);
    step("free4", '0, '0, 10'b10);
    chk("free4.back_on", 64'(on_off_o), 64'h3FF);

    step("to5", 5'b00001, 5'b00001, '0);
    step("sendfree", 5'b00001, 5'b00001, 10'b10);
    chk("sendfree.occ", 64'(occupancy_o[1*CW +: CW]), 64'd5);
    chk("sendfree.on", 64'(on_off_o[1]), 64'd1);

    do_reset();
    for (int i = 1; i <= 9; i++) step("ovf", 5'b00001, 5'b00001, '0);
    chk("ovf.occ", 64'(occupancy_o[1*CW +: CW]), 64'd8);
    chk("ovf.flag", 64'(overflow_err_o), 64'd1);
    step("ovf.idle", '0, '0, '0);
    chk("ovf.sticky", 64'(overflow_err_o), 64'd1);

    step("unf", '0, '0, 10'b01);
    chk("unf.occ", 64'(occupancy_o[0 +: CW]), 64'd0);
    chk("unf.flag", 64'(underflow_err_o), 64'd1);

    // Asynchronous reset mid-traffic discards counts and errors.
    step("pre_rst", 5'b11111, 5'b10101, '0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("midrst");
    chk("midrst.errs_clear", 64'({overflow_err_o, underflow_err_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Alternating fill-heavy / drain-heavy phases exercise both thresholds.
    for (int i = 0; i < 600; i++) begin
      logic [PN-1:0]    s, vcs;
      logic [PN*VN-1:0] fr;
      bit fill;
      fill = ((i / 40) % 2) == 0;
      for (int p = 0; p < PN; p++) begin
        s[p]   = ($urandom_range(99) < (fill ? 75 : 20));
        vcs[p] = 1'($urandom);
      end
      for (int b = 0; b < PN*VN; b++) fr[b] = ($urandom_range(99) < (fill ? 15 : 55));
      step("rand", s, vcs, fr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
